// File: rtl/sd_prio_ager.sv
// Dynamic priority and eligibility generator for the srdy/drdy priority mux:
// waiting requests age upward in priority, and per-input token buckets gate the mask.
module sd_prio_ager #(
  parameter int inputs        = 2,
  parameter int prio_width    = 4,
  parameter int age_width     = 8,
  parameter int age_shift     = 4,
  parameter int tok_width     = 8,
  parameter int refill_period = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [inputs-1:0]            req,
  input  logic [inputs-1:0]            ack,
  input  logic [prio_width*inputs-1:0] base_prio,
  input  logic [inputs-1:0]            rate_en,
  input  logic [tok_width*inputs-1:0]  tok_add,
  input  logic [tok_width*inputs-1:0]  tok_cap,
  output logic [prio_width*inputs-1:0] prio,
  output logic [inputs-1:0]            mask,
  output logic [inputs-1:0]            starve,
  output logic [inputs-1:0]            tok_err
);

  localparam int AGE_W = (age_width > age_shift) ? age_width - age_shift : 1;
  localparam int SUM_W = ((prio_width > AGE_W) ? prio_width : AGE_W) + 1;
  localparam int RC_W  = (refill_period > 1) ? $clog2(refill_period) : 1;
  localparam logic [age_width-1:0] AGE_MAX  = '1;
  localparam logic [SUM_W-1:0]     PRIO_MAX = {{(SUM_W-prio_width){1'b0}}, {prio_width{1'b1}}};

  logic [RC_W-1:0] rc_reg;
  logic            init_reg;
  logic            strobe;

  assign strobe = (rc_reg == RC_W'(refill_period - 1));

  // The init cycle loads full buckets and freezes the refill phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      rc_reg   <= '0;
      init_reg <= 1'b1;
    end else if (init_reg) begin
      init_reg <= 1'b0;
    end else begin
      rc_reg <= strobe ? '0 : rc_reg + RC_W'(1);
    end
  end

  for (genvar gi = 0; gi < inputs; gi++) begin : g_in
    logic [prio_width-1:0] base;
    logic [tok_width-1:0]  add;
    logic [tok_width-1:0]  cap;
    logic [age_width-1:0]  wait_reg;
    logic [age_width-1:0]  wait_next;
    logic [tok_width-1:0]  tok_reg;
    logic [tok_width-1:0]  tok_next;
    logic [tok_width:0]    tok_sum;
    logic [SUM_W-1:0]      aged;
    logic [prio_width-1:0] prio_next;
    logic [prio_width-1:0] prio_reg;
    logic                  mask_reg;
    logic                  starve_reg;
    logic                  err_reg;
    logic                  xfer;
    logic                  consume;
    logic                  underflow;

    assign base      = base_prio[gi*prio_width +: prio_width];
    assign add       = tok_add[gi*tok_width +: tok_width];
    assign cap       = tok_cap[gi*tok_width +: tok_width];
    assign xfer      = req[gi] & ack[gi] & ~init_reg;
    assign consume   = xfer & rate_en[gi];
    assign underflow = consume & (tok_reg == '0);

    always_comb begin
      wait_next = wait_reg;
      if (!init_reg) begin
        if (xfer || !req[gi]) begin
          wait_next = '0;
        end else if (wait_reg != AGE_MAX) begin
          wait_next = wait_reg + age_width'(1);
        end
      end
    end

    // Consume and refill combine at one extra bit, then clamp to capacity.
    always_comb begin
      tok_sum = {1'b0, tok_reg};
      if (consume && !underflow) begin
        tok_sum = tok_sum - (tok_width+1)'(1);
      end
      if (strobe) begin
        tok_sum = tok_sum + {1'b0, add};
      end
      if (init_reg || (tok_sum > {1'b0, cap})) begin
        tok_next = cap;
      end else begin
        tok_next = tok_sum[tok_width-1:0];
      end
    end

    always_comb begin
      aged      = {{(SUM_W-prio_width){1'b0}}, base} + SUM_W'(wait_next >> age_shift);
      prio_next = (aged > PRIO_MAX) ? PRIO_MAX[prio_width-1:0] : aged[prio_width-1:0];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wait_reg   <= '0;
        tok_reg    <= '0;
        prio_reg   <= '0;
        mask_reg   <= 1'b0;
        starve_reg <= 1'b0;
        err_reg    <= 1'b0;
      end else begin
        wait_reg   <= wait_next;
        tok_reg    <= tok_next;
        prio_reg   <= prio_next;
        mask_reg   <= ~rate_en[gi] | (tok_next != '0);
        starve_reg <= (wait_next == AGE_MAX);
        if (underflow) begin
          err_reg <= 1'b1;
        end
      end
    end

    assign prio[gi*prio_width +: prio_width] = prio_reg;
    assign mask[gi]    = mask_reg;
    assign starve[gi]  = starve_reg;
    assign tok_err[gi] = err_reg;
  end

endmodule

// File: tb/tb_sd_prio_ager.sv
// Scoreboard bench for sd_prio_ager: a cycle model predicts the registered outputs,
// which are queued at drive time and compared after the following clock edge.
module tb_sd_prio_ager;
  localparam int N  = 2;
  localparam int PW = 4;
  localparam int AW = 8;
  localparam int AS = 4;
  localparam int TW = 8;
  localparam int RP = 16;
  localparam int AGE_MAX  = (1 << AW) - 1;
  localparam int PRIO_MAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, ack, rate_en;
  logic [PW*N-1:0] base_prio;
  logic [TW*N-1:0] tok_add, tok_cap;
  logic [PW*N-1:0] prio;
  logic [N-1:0]  mask, starve, tok_err;

  always #5 clk = ~clk;

  sd_prio_ager #(
    .inputs(N), .prio_width(PW), .age_width(AW), .age_shift(AS),
    .tok_width(TW), .refill_period(RP)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack), .base_prio(base_prio),
    .rate_en(rate_en), .tok_add(tok_add), .tok_cap(tok_cap),
    .prio(prio), .mask(mask), .starve(starve), .tok_err(tok_err)
  );

  typedef struct packed {
    logic [PW*N-1:0] prio;
    logic [N-1:0]    mask;
    logic [N-1:0]    starve;
    logic [N-1:0]    err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;

  int   m_wait[N];
  int   m_tok[N];
  int   m_rc;
  bit   m_init;
  logic [PW*N-1:0] m_prio;
  logic [N-1:0]    m_mask, m_starve, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cycle);
    end
  endtask

  // Predict the outputs registered at the next edge from the current inputs.
  task automatic model_cycle(output exp_t e);
    bit strobe;
    int base, add, cap, t, p;
    bit xfer;
    if (reset) begin
      for (int j = 0; j < N; j++) begin
        m_wait[j] = 0;
        m_tok[j]  = 0;
      end
      m_rc = 0; m_init = 1'b1;
      m_prio = '0; m_mask = '0; m_starve = '0; m_err = '0;
    end else begin
      strobe = (m_rc == RP - 1);
      for (int j = 0; j < N; j++) begin
        base = int'(base_prio[j*PW +: PW]);
        add  = int'(tok_add[j*TW +: TW]);
        cap  = int'(tok_cap[j*TW +: TW]);
        if (m_init) begin
          m_tok[j] = cap;
        end else begin
          xfer = req[j] && ack[j];
          if (xfer || !req[j]) m_wait[j] = 0;
          else if (m_wait[j] < AGE_MAX) m_wait[j] = m_wait[j] + 1;
          t = m_tok[j];
          if (xfer && rate_en[j]) begin
            if (t == 0) m_err[j] = 1'b1;
            else t = t - 1;
          end
          if (strobe) t = t + add;
          m_tok[j] = (t > cap) ? cap : t;
        end
        p = base + (m_wait[j] >> AS);
        if (p > PRIO_MAX) p = PRIO_MAX;
        m_prio[j*PW +: PW] = PW'(p);
        m_mask[j]   = !rate_en[j] || (m_tok[j] != 0);
        m_starve[j] = (m_wait[j] == AGE_MAX);
      end
      if (m_init) m_init = 1'b0;
      else m_rc = strobe ? 0 : m_rc + 1;
    end
    e.prio = m_prio; e.mask = m_mask; e.starve = m_starve; e.err = m_err;
  endtask

  task automatic step();
    exp_t e;
    model_cycle(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    cycle++;
    e = sb.pop_front();
    if (!reset && |(req & ack))
      $display("cycle %0d xfer=%b prio=%h mask=%b starve=%b tok_err=%b",
               cycle, req & ack, prio, mask, starve, tok_err);
    chk("prio", prio, e.prio);
    chk("mask", mask, e.mask);
    chk("starve", starve, e.starve);
    chk("tok_err", tok_err, e.err);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    int n;
    req = '0; ack = '0; rate_en = '1;
    base_prio = {4'd5, 4'd2};
    tok_add   = {8'd1, 8'd1};
    tok_cap   = {8'd3, 8'd3};
    reset = 1'b1;
    step(); step();
    chk("rst_prio", prio, 0);
    chk("rst_mask", mask, 0);
    reset = 1'b0;
    step();
    chk("init_mask", mask, 2'b11);

    // Aging on input 0.
    req = 2'b01; ack = 2'b00;
    for (int i = 0; i < 15; i++) step();
    chk("age15", prio[3:0], 2);
    step();
    chk("age16", prio[3:0], 3);
    for (int i = 0; i < 32; i++) step();
    chk("age48", prio[3:0], 5);
    ack = 2'b01;
    step();
    chk("age_clear", prio[3:0], 2);
    req = '0; ack = '0;
    step();

    // Clamp and starvation on input 1.
    base_prio = {4'd14, 4'd2};
    req = 2'b10;
    for (int i = 0; i < 254; i++) step();
    chk("starve254", starve, 2'b00);
    chk("clamp", prio[7:4], 15);
    step();
    chk("starve255", starve, 2'b10);
    for (int i = 0; i < 5; i++) step();
    chk("starve_hold", starve, 2'b10);
    chk("clamp_hold", prio[7:4], 15);
    req = '0;
    step();
    chk("starve_drop", starve, 2'b00);

    // Token drain and refill on input 0.
    base_prio = {4'd5, 4'd2};
    tok_cap = {8'd2, 8'd2};
    do_reset();
    req = 2'b01; ack = 2'b01;
    step();
    chk("drain1", mask[0], 1);
    step();
    chk("drain2", mask[0], 0);
    req = '0; ack = '0;
    n = 0;
    while (mask[0] == 1'b0 && n < 20) begin
      step();
      n++;
    end
    chk("refill_steps", n, 14);

    // Refill on the same cycle as a consume keeps a full bucket full.
    for (int i = 0; i < 31; i++) step();
    req = 2'b01; ack = 2'b01;
    step();
    chk("balanced", mask[0], 1);
    step();
    chk("after_bal1", mask[0], 1);
    step();
    chk("after_bal2", mask[0], 0);
    step();
    chk("underflow_err", tok_err, 2'b01);
    chk("underflow_mask", mask[0], 0);
    req = '0; ack = '0;
    for (int i = 0; i < 3; i++) step();
    chk("err_sticky", tok_err, 2'b01);

    // Input 1 without rate limiting.
    rate_en = 2'b01;
    req = 2'b10; ack = 2'b10;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("unlim_mask", mask[1], 1);
      chk("unlim_err", tok_err[1], 0);
    end

    // Random traffic.
    tok_cap = {8'd3, 8'd2};
    tok_add = {8'd2, 8'd1};
    do_reset();
    for (int i = 0; i < 300; i++) begin
      req = N'($urandom);
      ack = N'($urandom);
      if (i % 50 == 0) rate_en = N'($urandom);
      step();
    end

    req = '0; ack = '0;
    reset = 1'b1;
    step();
    chk("final_err_clr", tok_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_prio_ager.md
Name: sd_prio_ager

Overview:
- Upstream control stage for the srdy/drdy priority round-robin mux.
- Generates each input's dynamic priority (prio) and eligibility mask (mask) from the mux's own per-input srdy/drdy handshake.
- Priority ages upward while a request waits unserved, so low-priority requesters cannot starve.
- A per-input token bucket rate-limits inputs through the mask.

Parameters:
- inputs, 2, number of arbitrated inputs.
- prio_width, 4, width of each priority field; must match the mux.
- age_width, 8, width of each saturating wait counter.
- age_shift, 4, wait cycles per priority step are 2^age_shift.
- tok_width, 8, width of each token counter, tok_add field and tok_cap field.
- refill_period, 16, cycles between token refills; must be ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  inputs  per-input srdy as seen by the mux.
- ack  in  inputs  per-input drdy from the mux; a transfer on input j is req[j]&ack[j].
- base_prio  in  prio_width*inputs  static priority per input; field j is bits [j*prio_width +: prio_width].
- rate_en  in  inputs  1 enables token limiting on input j.
- tok_add  in  tok_width*inputs  tokens added to input j at each refill.
- tok_cap  in  tok_width*inputs  bucket capacity of input j.
- prio  out  prio_width*inputs  registered dynamic priority, wired to the mux prio port.
- mask  out  inputs  registered eligibility, wired to the mux mask port.
- starve  out  inputs  registered; 1 while wait_cnt[j] is saturated.
- tok_err  out  inputs  sticky; set on a transfer while the bucket is empty and rate_en is 1.

Behaviour:
- Reset: in any cycle with reset=1, the following load at the clock edge:
  - wait_cnt=0, tok=0, refill counter rc=0, init=1;
  - prio=0, mask=0, starve=0, tok_err=0.
  - Reset mid-operation discards all state.
- Init cycle: the first cycle after reset deasserts has init=1. At its edge:
  - tok[j]<=tok_cap[j]; init<=0.
  - rc does not advance.
  - No transfer accounting occurs; transfers in this cycle are ignored.
- Wait counter, per j, when init=0:
  - transfer → 0;
  - else req[j]=0 → 0;
  - else (req & !ack) → wait_cnt+1, saturating at 2^age_width-1.
- Aged priority, per j: a = base_prio[j] + (wait_cnt_next[j] >> age_shift).
  - Compute at max(prio_width, age_width-age_shift)+1 bits.
  - Clamp at 2^prio_width-1.
  - Register into prio field j.
- Refill counter:
  - rc counts 0..refill_period-1 and wraps; refill strobe = (rc == refill_period-1).
  - refill_period=1 → strobe every cycle.
- Token update, per j, at tok_width+1 bits:
  - t = tok - consume + (strobe ? tok_add : 0), where consume = transfer & rate_en.
  - Next value is min(t, tok_cap).
  - Consume with tok=0: that term is dropped (no underflow) and tok_err[j] sets.
  - Simultaneous consume and refill: both apply in the same cycle.
  - rate_en=0: the bucket still refills but is never consumed.
- Mask: mask[j] <= !rate_en[j] | (tok_next[j] != 0).
  - Timing: a transfer consuming the last token at cycle t gives mask[j]=0 at t+1.
  - A refill at cycle t raises mask at t+1.
- Starve: starve[j] <= (wait_cnt_next[j] == 2^age_width-1).
- Latency: every output is registered; all outputs reflect handshake events one cycle later.
- Combinational paths: none from req/ack to any output. This keeps the block loop-free in front of the zero-delay mux.
- tok_err clears only on reset.

Test Plan:
- Reset and init, with tok_cap=3 and rate_en=1 on all inputs:
  - Hold reset 2 cycles → prio=0, mask=0.
  - Release → mask=all-ones 1 cycle after the init cycle; tok=3.
- Aging, with inputs=2, base_prio={2,5}, age_shift=4:
  - Hold req[0]=1, ack[0]=0 for 48 cycles.
  - prio[0] steps 2→3→4→5 at wait_cnt 16/32/48; the step appears 1 cycle after the count is reached.
  - Then ack[0]=1 for one cycle → wait_cnt=0 and prio[0]=2 on the next cycle.
- Priority clamp: base_prio[1]=14, age_width=8, hold a stall for 255+ cycles.
  - prio[1] saturates at 15.
  - starve[1] rises after wait_cnt reaches 255 and stays high while the stall continues.
- Token drain and refill, with tok_cap=2, tok_add=1, refill_period=16:
  - 2 back-to-back transfers → mask[0]=0 the cycle after the 2nd.
  - Next strobe → tok=1 and mask=1 the following cycle.
- Simultaneous events and error:
  - tok=2 with a transfer on the strobe cycle and tok_add=1 → tok stays 2, capped and balanced.
  - Force a transfer with tok=0 → tok stays 0 and tok_err[0]=1, held until reset.
- rate_en=0 on input 1: unlimited back-to-back transfers → mask[1]=1 throughout and tok_err[1]=0.
